alu_share_ctrl: RTL and testbench

Controller that shares the team's single WIDTH-bit logic/arithmetic datapath (AND, OR, XOR, ADD) between two requesters. It arbitrates round-robin, latches the winner's opcode and operands, and sequences one operation through the datapath. It returns a registered result with a done pulse tagged with the requester id. It sits between the requesting blocks and the combinational ALU slice, which is instantiated inside it.

---
 rtl/alu_share_ctrl_pkg.sv | 15 +
 rtl/alu_share_ctrl_alu_core.sv | 33 +++
 rtl/alu_share_ctrl.sv | 103 ++++++++++
 tb/tb_alu_share_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared opcode constants and controller state encoding for the shared ALU slice.
package alu_share_ctrl_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_alu_core.sv
// Combinational logic/arithmetic slice: AND, OR, XOR and unsigned ADD with carry-out.
module alu_core
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_ADD: begin
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one ALU slice between two requesters.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    state_t           state;
    state_t           state_next;
    logic             last;
    logic             take;
    logic             pick1;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry;

    // Requester 1 wins when alone, or when contended and requester 0 was served last.
    assign take  = req0 | req1;
    assign pick1 = req1 & (~req0 | ~last);
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (take) state_next = S_EXEC;
            S_EXEC:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            y       <= '0;
            carry   <= 1'b0;
        end else begin
            gnt0 <= (state == S_IDLE) & take & ~pick1;
            gnt1 <= (state == S_IDLE) & take & pick1;
            done <= (state == S_EXEC);
            if (state == S_IDLE && take) begin
                last <= pick1;
            end
            if (state == S_EXEC) begin
                y       <= alu_y;
                carry   <= alu_carry;
                done_id <= last;
            end
        end
    end

    // Operand latches are pure data: captured only at grant, never reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && take) begin
            op_q <= pick1 ? op1 : op0;
            a_q  <= pick1 ? a1 : a0;
            b_q  <= pick1 ? b1 : b0;
        end
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .y     (alu_y),
        .carry (alu_carry)
    );

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed and randomized bench for alu_share_ctrl against a transaction-level reference.
module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic [1:0] op0 = 2'b00;
    logic [3:0] a0 = 4'h0;
    logic [3:0] b0 = 4'h0;
    logic       req1 = 1'b0;
    logic [1:0] op1 = 2'b00;
    logic [3:0] a1 = 4'h0;
    logic [3:0] b1 = 4'h0;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [3:0] y;
    logic       carry;

    int checks = 0;
    int errors = 0;
    bit rr_last = 1'b1;

    alu_share_ctrl #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .op0     (op0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .op1     (op1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .y       (y),
        .carry   (carry)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference ALU written from the arithmetic rules with plain integers.
    task automatic ref_alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           output logic [3:0] ey, output logic ec);
        int s;
        ec = 1'b0;
        case (op)
            OP_AND: ey = a & b;
            OP_OR:  ey = a | b;
            OP_XOR: ey = a ^ b;
            default: begin
                s  = int'(a) + int'(b);
                ey = 4'(s % 16);
                ec = (s > 15);
            end
        endcase
    endtask

    task automatic wait_grant(input bit w, input string tag);
        tick();
        chk({tag, "_gnt0"}, 8'(gnt0), 8'(!w));
        chk({tag, "_gnt1"}, 8'(gnt1), 8'(w));
        chk({tag, "_busy_exec"}, 8'(busy), 8'd1);
        chk({tag, "_done_exec"}, 8'(done), 8'd0);
    endtask

    task automatic wait_done(input bit w, input logic [3:0] ey, input logic ec, input string tag);
        tick();
        chk({tag, "_done"}, 8'(done), 8'd1);
        chk({tag, "_done_id"}, 8'(done_id), 8'(w));
        chk({tag, "_y"}, 8'(y), 8'(ey));
        chk({tag, "_carry"}, 8'(carry), 8'(ec));
        chk({tag, "_busy_done"}, 8'(busy), 8'd1);
        chk({tag, "_gnt_in_done"}, 8'({gnt1, gnt0}), 8'd0);
    endtask

    task automatic finish_idle(input logic [3:0] ey, input string tag);
        tick();
        chk({tag, "_busy_idle"}, 8'(busy), 8'd0);
        chk({tag, "_done_idle"}, 8'(done), 8'd0);
        chk({tag, "_gnt_idle"}, 8'({gnt1, gnt0}), 8'd0);
        chk({tag, "_y_hold"}, 8'(y), 8'(ey));
    endtask

    task automatic run_txn(input bit keep, input string tag);
        bit         w;
        logic [3:0] ey;
        logic       ec;
        w = (req0 && req1) ? !rr_last : req1;
        if (w) ref_alu(op1, a1, b1, ey, ec);
        else   ref_alu(op0, a0, b0, ey, ec);
        rr_last = w;
        wait_grant(w, tag);
        if (!keep) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        wait_done(w, ey, ec, tag);
        finish_idle(ey, tag);
    endtask

    task automatic do_reset(input string tag);
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk({tag, "_rst_gnt"}, 8'({gnt1, gnt0}), 8'd0);
        chk({tag, "_rst_busy"}, 8'(busy), 8'd0);
        chk({tag, "_rst_done"}, 8'(done), 8'd0);
        chk({tag, "_rst_done_id"}, 8'(done_id), 8'd0);
        chk({tag, "_rst_y"}, 8'(y), 8'd0);
        chk({tag, "_rst_carry"}, 8'(carry), 8'd0);
        tick();
        rst = 1'b0;
        rr_last = 1'b1;
    endtask

    task automatic rand_operands();
        op0 = 2'($urandom);
        a0  = 4'($urandom);
        b0  = 4'($urandom);
        op1 = 2'($urandom);
        a1  = 4'($urandom);
        b1  = 4'($urandom);
    endtask

    initial begin
        logic [3:0] ey;
        logic       ec;

        do_reset("init");

        // Single XOR request from requester 0.
        req0 = 1'b1; op0 = OP_XOR; a0 = 4'b1100; b0 = 4'b1010;
        run_txn(1'b0, "xor_single");

        // Contended from reset: grants alternate 0,1,0,1 three cycles apart.
        do_reset("rr");
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_operands();
            chk("rr_expected_winner", 8'(!rr_last), 8'(k % 2));
            run_txn(1'b1, "rr");
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // ADD wrap-around on requester 1.
        req1 = 1'b1; op1 = OP_ADD; a1 = 4'hF; b1 = 4'h1;
        rr_last = 1'b1;
        wait_grant(1'b1, "add_wrap");
        req1 = 1'b0;
        wait_done(1'b1, 4'h0, 1'b1, "add_wrap");
        finish_idle(4'h0, "add_wrap");
        req1 = 1'b1; a1 = 4'h7; b1 = 4'h8;
        wait_grant(1'b1, "add_nowrap");
        req1 = 1'b0;
        wait_done(1'b1, 4'hF, 1'b0, "add_nowrap");
        finish_idle(4'hF, "add_nowrap");

        // Operands change right after grant; latched values must be used.
        req0 = 1'b1; op0 = OP_AND; a0 = 4'h3; b0 = 4'h5;
        rr_last = 1'b0;
        wait_grant(1'b0, "late_change");
        req0 = 1'b0; a0 = 4'hF;
        wait_done(1'b0, 4'h1, 1'b0, "late_change");
        finish_idle(4'h1, "late_change");

        // Reset while in EXEC: no done, outputs cleared, pointer back to favour requester 0.
        rand_operands();
        req0 = 1'b1;
        req1 = 1'b1;
        wait_grant(!rr_last, "mid_rst");
        rst = 1'b1;
        tick();
        chk("mid_rst_done", 8'(done), 8'd0);
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_y", 8'(y), 8'd0);
        chk("mid_rst_carry", 8'(carry), 8'd0);
        chk("mid_rst_done_id", 8'(done_id), 8'd0);
        chk("mid_rst_gnt", 8'({gnt1, gnt0}), 8'd0);
        rst = 1'b0;
        rr_last = 1'b1;
        chk("post_rst_winner", 8'(!rr_last), 8'd0);
        run_txn(1'b0, "post_rst");

        // Exhaustive XOR sweep through requester 0.
        for (int i = 0; i < 256; i++) begin
            req0 = 1'b1;
            op0  = OP_XOR;
            a0   = 4'(i / 16);
            b0   = 4'(i % 16);
            ref_alu(OP_XOR, a0, b0, ey, ec);
            chk("xor_sweep_model", 8'({ec, ey}), 8'({1'b0, a0 ^ b0}));
            run_txn(1'b0, "xor_sweep");
        end

        // Random request patterns and operations.
        for (int i = 0; i < 60; i++) begin
            rand_operands();
            req0 = 1'($urandom_range(0, 1));
            req1 = req0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(1'b0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
